id_ex_stage: RTL

- ID/EX pipeline register sitting directly downstream of the register file.
- Captures the decoded instruction and both register-file read operands each cycle.
- Detects load-use hazards, inserting a bubble and stalling IF/ID.
- Applies EX-stage operand forwarding from the MEM and WB stages, producing the final ALU/store operands.

---
 rtl/id_ex_stage_pkg.sv | 38 +++
 rtl/id_ex_stage_operand_forward.sv | 65 ++++++
 rtl/id_ex_stage.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_pkg.sv
// ----------------------------------------------------------------------------
// id_ex_stage_pkg
//
// Purpose:
//   Shared constants for the ID/EX pipeline stage and its operand
//   forwarding sub-module:
//     - forward-select encodings
//     - the hard-wired zero register number
//     - default data and control-bundle widths
//   A small helper also decides whether a downstream writer targets a given
//   source register.
//
// Ports: none (package).
// ----------------------------------------------------------------------------
package id_ex_stage_pkg;

    // Forward-select encodings driven on ex_fwd_a / ex_fwd_b.
    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    // Register $0 reads as zero, so it never forwards and never stalls.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Default widths for the stage.
    localparam int DATA_W_DEFAULT = 32;
    localparam int CTRL_W_DEFAULT = 8;

    // True when a writer with enable 'we' and destination 'dst' produces the
    // value that source register 'src' is asking for. Writes to $0 are
    // discarded by the register file, so they never count as a match.
    function automatic logic dst_matches(input logic       we,
                                         input logic [4:0] dst,
                                         input logic [4:0] src);
        return we && (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

// File: rtl/id_ex_stage_operand_forward.sv
// ----------------------------------------------------------------------------
// operand_forward
//
// Purpose:
//   Bypass multiplexer for a single EX-stage source operand. It picks the
//   newest copy of the register:
//     1. the MEM-stage ALU result, if MEM writes this register;
//     2. otherwise the WB-stage write data, if WB writes this register;
//     3. otherwise the value read from the register file in ID.
//   The top instantiates one copy for rs and one for rt.
//
// Parameters:
//   DATA_W         operand width
//
// Ports:
//   reg_num        in   5       source register number held in ID/EX
//   reg_data       in   DATA_W  register-file value captured in ID/EX
//   mem_reg_write  in   1       MEM-stage writeback enable
//   mem_dst        in   5       MEM-stage destination register
//   mem_result     in   DATA_W  MEM-stage ALU result
//   wb_reg_write   in   1       WB-stage writeback enable
//   wb_dst         in   5       WB-stage destination register
//   wb_data        in   DATA_W  WB-stage write data
//   data           out  DATA_W  selected operand
//   sel            out  2       FWD_REG / FWD_MEM / FWD_WB
// ----------------------------------------------------------------------------
module operand_forward
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic [4:0]        reg_num,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              mem_reg_write,
    input  logic [4:0]        mem_dst,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_dst,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] data,
    output logic [1:0]        sel
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = dst_matches(mem_reg_write, mem_dst, reg_num);
    assign wb_hit  = dst_matches(wb_reg_write, wb_dst, reg_num);

    // MEM is checked first because it holds the younger instruction. When
    // MEM and WB both write the same register, MEM's value is the one the
    // program order expects.
    always_comb begin
        sel  = FWD_REG;
        data = reg_data;
        if (mem_hit) begin
            sel  = FWD_MEM;
            data = mem_result;
        end else if (wb_hit) begin
            sel  = FWD_WB;
            data = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
//
// Purpose:
//   ID/EX pipeline register that sits directly after the register file.
//   Each cycle it captures:
//     - the decoded instruction
//     - both register-file read operands
//   It also handles hazards and bypassing:
//     - Load-use hazard: when the instruction in EX is a load whose result
//       the ID instruction needs, the stage loads a bubble and raises 'stall'
//       so that PC and IF/ID hold. On the next cycle the dependent
//       instruction enters again and picks up the loaded value through
//       forwarding.
//     - Forwarding: the final ALU/store operands are built from the MEM and
//       WB bypass paths.
//
// Optional build macro:
//   ID_EX_STALL_COUNT_EN  adds a free-running 32-bit count of stall cycles
//                         (output stall_count).
//
// Parameters:
//   DATA_W   operand/immediate width
//   CTRL_W   opaque EX/MEM/WB control bundle width (passed through)
//
// Ports:
//   clk, reset                       clock, async active-high reset
//   id_valid                         ID holds a real instruction
//   id_rs, id_rt, id_dst             source/destination register numbers
//   id_uses_rs, id_uses_rt           instruction really reads rs/rt
//   id_reg_write/mem_read/mem_write  decoded controls
//   id_rs_data, id_rt_data           register-file read data
//   id_imm, id_ctrl                  immediate, remaining controls
//   flush                            taken branch/jump in EX kills ID
//   mem_reg_write, mem_dst, mem_result  MEM-stage bypass source
//   wb_reg_write, wb_dst, wb_data       WB-stage bypass source
//   stall                            hold PC and IF/ID this cycle
//   ex_*                             registered EX-stage fields
//   ex_op_a, ex_op_b                 forwarded rs/rt operands
//   ex_fwd_a, ex_fwd_b               forward selects (0 reg, 1 MEM, 2 WB)
//   stall_count                      stall cycle counter (optional)
// ----------------------------------------------------------------------------
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int CTRL_W = CTRL_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_dst,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush,
    input  logic              mem_reg_write,
    input  logic [4:0]        mem_dst,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_dst,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_dst,
    output logic [DATA_W-1:0] ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DATA_W-1:0] ex_op_a,
    output logic [DATA_W-1:0] ex_op_b,
    output logic [1:0]        ex_fwd_a,
    output logic [1:0]        ex_fwd_b
`ifdef ID_EX_STALL_COUNT_EN
    ,
    output logic [31:0]       stall_count
`endif
);

    logic              hz;
    logic              rs_conflict;
    logic              rt_conflict;
    logic              bubble;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;

    // Load-use detection. The EX instruction is a real load to a nonzero
    // register, and the ID instruction really reads that register through
    // rs or rt. Register numbers that the ID instruction does not use are
    // ignored, so stale encoding bits cannot cause stalls.
    assign rs_conflict = id_uses_rs && (id_rs == ex_dst);
    assign rt_conflict = id_uses_rt && (id_rt == ex_dst);
    assign hz = ex_valid && ex_mem_read && (ex_dst != REG_ZERO) && id_valid
                && (rs_conflict || rt_conflict);

    // A flushed instruction is discarded anyway, so stalling for it would
    // only waste a cycle. Flush therefore masks the stall.
    assign stall  = hz && !flush;
    assign bubble = flush || hz;

    // ID/EX register. The stage never holds its contents. A hazard pushes
    // a bubble and lets the load move on to MEM, and IF/ID re-presents the
    // dependent instruction on the next cycle. Bubbles clear every field so
    // that the stage contents are always deterministic. An invalid ID slot
    // is captured, but its side-effecting controls are masked off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_rs        <= REG_ZERO;
            ex_rt        <= REG_ZERO;
            ex_dst       <= REG_ZERO;
            ex_imm       <= '0;
            ex_ctrl      <= '0;
            ex_rs_data   <= '0;
            ex_rt_data   <= '0;
        end else if (bubble) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_rs        <= REG_ZERO;
            ex_rt        <= REG_ZERO;
            ex_dst       <= REG_ZERO;
            ex_imm       <= '0;
            ex_ctrl      <= '0;
            ex_rs_data   <= '0;
            ex_rt_data   <= '0;
        end else begin
            ex_valid     <= id_valid;
            ex_reg_write <= id_valid && id_reg_write;
            ex_mem_read  <= id_valid && id_mem_read;
            ex_mem_write <= id_valid && id_mem_write;
            ex_rs        <= id_rs;
            ex_rt        <= id_rt;
            ex_dst       <= id_dst;
            ex_imm       <= id_imm;
            ex_ctrl      <= id_ctrl;
            ex_rs_data   <= id_rs_data;
            ex_rt_data   <= id_rt_data;
        end
    end

    // Forwarding runs combinationally after the register, so the operands
    // are valid in the same cycle as ex_valid.
    operand_forward #(
        .DATA_W (DATA_W)
    ) u_fwd_a (
        .reg_num       (ex_rs),
        .reg_data      (ex_rs_data),
        .mem_reg_write (mem_reg_write),
        .mem_dst       (mem_dst),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_dst        (wb_dst),
        .wb_data       (wb_data),
        .data          (ex_op_a),
        .sel           (ex_fwd_a)
    );

    operand_forward #(
        .DATA_W (DATA_W)
    ) u_fwd_b (
        .reg_num       (ex_rt),
        .reg_data      (ex_rt_data),
        .mem_reg_write (mem_reg_write),
        .mem_dst       (mem_dst),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_dst        (wb_dst),
        .wb_data       (wb_data),
        .data          (ex_op_b),
        .sel           (ex_fwd_b)
    );

`ifdef ID_EX_STALL_COUNT_EN
    // Stall cycle counter. Flushed hazards are already excluded because
    // 'stall' is masked by flush. The counter wraps naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= 32'd0;
        end else if (stall) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule
